max7219_chain_ctrl: RTL and testbench

MAX7219_CHAIN_CTRL -- requirements
Module: max7219_chain_ctrl

---
 rtl/max7219_ctrl_pkg.sv | 47 ++++
 rtl/max7219_clk_tick.sv | 45 ++++
 rtl/max7219_chain_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_max7219_chain_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_ctrl_pkg.sv
// Shared definitions for the MAX7219 daisy-chain controller: register
// addresses, controller state encoding and the power-up init table.
package max7219_ctrl_pkg;

    localparam logic [3:0] REG_NOOP       = 4'h0;
    localparam logic [3:0] REG_DIGIT0     = 4'h1;
    localparam logic [3:0] REG_DIGIT1     = 4'h2;
    localparam logic [3:0] REG_DIGIT2     = 4'h3;
    localparam logic [3:0] REG_DIGIT3     = 4'h4;
    localparam logic [3:0] REG_DIGIT4     = 4'h5;
    localparam logic [3:0] REG_DIGIT5     = 4'h6;
    localparam logic [3:0] REG_DIGIT6     = 4'h7;
    localparam logic [3:0] REG_DIGIT7     = 4'h8;
    localparam logic [3:0] REG_DECODE     = 4'h9;
    localparam logic [3:0] REG_INTENSITY  = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
    localparam logic [3:0] REG_TEST       = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_GUARD    = 3'd4
    } state_e;

    // Number of broadcast frames in the power-up sequence and last index.
    localparam int unsigned INIT_LEN      = 5;
    localparam logic [2:0]  INIT_LAST_IDX = 3'd4;

    // Power-up table: leave shutdown, scan all 8 digits, no decode,
    // mid intensity, display test off. Each entry is one 16-bit device word.
    function automatic logic [15:0] init_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {4'h0, REG_SHUTDOWN,   8'h01};
            3'd1:    w = {4'h0, REG_SCAN_LIMIT, 8'h07};
            3'd2:    w = {4'h0, REG_DECODE,     8'h00};
            3'd3:    w = {4'h0, REG_INTENSITY,  8'h07};
            3'd4:    w = {4'h0, REG_TEST,       8'h00};
            default: w = {4'h0, REG_NOOP,       8'h00};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_clk_tick.sv
// Half-period timebase for the MAX7219 serial clock: while enabled, emits a
// one-cycle tick on the last cycle of every G_CLK_DIV-cycle window. The
// counter restarts from zero whenever the enable drops.
module max7219_clk_tick
    import max7219_ctrl_pkg::*;
#(
    parameter int G_CLK_DIV = 4
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(G_CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear when disabled or at the end of a window.
    always_comb begin
        cnt_d = cnt_q;
        if (!i_en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // Window counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/max7219_chain_ctrl.sv
// Frame controller for a chain of G_NB_MATRIX MAX7219 devices. A write sends
// one 16-bit word per device (farthest device first, MSB first), then pulses
// LOAD. Define MAX7219_CHAIN_INIT_SEQ_EN to send the power-up configuration
// frames automatically after reset; otherwise o_init_done is tied high.
module max7219_chain_ctrl
    import max7219_ctrl_pkg::*;
#(
    parameter int G_NB_MATRIX = 8,
    parameter int G_CLK_DIV   = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [3:0]               i_addr,
    input  logic [8*G_NB_MATRIX-1:0] i_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_req_drop,
    output logic                     o_init_done,
    output logic                     o_max7219_clk,
    output logic                     o_max7219_din,
    output logic                     o_max7219_load
);

    localparam int FRAME_BITS = 16 * G_NB_MATRIX;
    localparam int BCNT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_BITS);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(1);

    // Device i occupies bits [16i+15:16i]; the top word leaves first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [3:0]               addr,
        input logic [8*G_NB_MATRIX-1:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < G_NB_MATRIX; i++) begin
            f[16*i +: 16] = {4'h0, addr, data[8*i +: 8]};
        end
        return f;
    endfunction

    state_e                state_q,   state_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  drop_q,    drop_d;
    logic                  sclk_q,    sclk_d;
    logic                  din_q,     din_d;
    logic                  load_q,    load_d;
    logic [FRAME_BITS-1:0] frame_q,   frame_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;

    logic                  tick_s;
    logic                  tick_en_s;
    logic                  start_s;
    logic [FRAME_BITS-1:0] new_frame_s;

`ifdef MAX7219_CHAIN_INIT_SEQ_EN
    logic                  init_active_q, init_active_d;
    logic [2:0]            init_idx_q,    init_idx_d;
    logic                  init_done_q,   init_done_d;
    logic [FRAME_BITS-1:0] init_frame_cur_s;
    logic [FRAME_BITS-1:0] init_frame_nxt_s;
`endif

    assign tick_en_s = (state_q != ST_IDLE);

    max7219_clk_tick #(
        .G_CLK_DIV (G_CLK_DIV)
    ) u_clk_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (tick_en_s),
        .o_tick (tick_s)
    );

    // Next-state and serial bus outputs; a frame start is decided in the
    // case statement and applied once at the bottom.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        drop_d      = i_wr_en & busy_q;
        sclk_d      = sclk_q;
        din_d       = din_q;
        load_d      = load_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        start_s     = 1'b0;
        new_frame_s = '0;
`ifdef MAX7219_CHAIN_INIT_SEQ_EN
        init_active_d    = init_active_q;
        init_idx_d       = init_idx_q;
        init_done_d      = init_done_q;
        init_frame_cur_s = {G_NB_MATRIX{init_word(init_idx_q)}};
        init_frame_nxt_s = {G_NB_MATRIX{init_word(init_idx_q + 3'd1)}};
`endif

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                load_d = 1'b0;
                din_d  = 1'b0;
`ifdef MAX7219_CHAIN_INIT_SEQ_EN
                // The init sequence owns the bus; a user write here is dropped.
                if (init_active_q) begin
                    start_s     = 1'b1;
                    new_frame_s = init_frame_cur_s;
                    drop_d      = i_wr_en;
                end else if (i_wr_en) begin
                    start_s     = 1'b1;
                    new_frame_s = build_frame(i_addr, i_data);
                end else begin
                    start_s     = 1'b0;
                end
`else
                if (i_wr_en) begin
                    start_s     = 1'b1;
                    new_frame_s = build_frame(i_addr, i_data);
                end else begin
                    start_s     = 1'b0;
                end
`endif
            end

            ST_SHIFT_LO: begin
                if (tick_s) begin
                    state_d = ST_SHIFT_HI;
                    sclk_d  = 1'b1;
                end else begin
                    state_d = ST_SHIFT_LO;
                end
            end

            ST_SHIFT_HI: begin
                if (tick_s) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == BCNT_LAST) begin
                        state_d = ST_LATCH;
                        load_d  = 1'b1;
                    end else begin
                        state_d   = ST_SHIFT_LO;
                        din_d     = frame_q[FRAME_BITS-1];
                        frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BCNT_LAST;
                    end
                end else begin
                    state_d = ST_SHIFT_HI;
                end
            end

            ST_LATCH: begin
                if (tick_s) begin
                    state_d = ST_GUARD;
                    load_d  = 1'b0;
                end else begin
                    state_d = ST_LATCH;
                end
            end

            ST_GUARD: begin
                if (tick_s) begin
`ifdef MAX7219_CHAIN_INIT_SEQ_EN
                    // Init frames chain without an idle gap and without o_done.
                    if (init_active_q) begin
                        if (init_idx_q == INIT_LAST_IDX) begin
                            state_d       = ST_IDLE;
                            busy_d        = 1'b0;
                            din_d         = 1'b0;
                            init_active_d = 1'b0;
                            init_done_d   = 1'b1;
                        end else begin
                            init_idx_d  = init_idx_q + 3'd1;
                            start_s     = 1'b1;
                            new_frame_s = init_frame_nxt_s;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        din_d   = 1'b0;
                        done_d  = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    din_d   = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_GUARD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                din_d   = 1'b0;
                load_d  = 1'b0;
            end
        endcase

        // Starting a frame puts its first bit on DIN as SHIFT_LO is entered.
        if (start_s) begin
            state_d   = ST_SHIFT_LO;
            busy_d    = 1'b1;
            sclk_d    = 1'b0;
            load_d    = 1'b0;
            din_d     = new_frame_s[FRAME_BITS-1];
            frame_d   = {new_frame_s[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = BCNT_FULL;
        end else begin
            bit_cnt_d = bit_cnt_d;
        end
    end

    // Controller state, frame shifter and registered bus/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            sclk_q    <= 1'b0;
            din_q     <= 1'b0;
            load_q    <= 1'b0;
            frame_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            load_q    <= load_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

`ifdef MAX7219_CHAIN_INIT_SEQ_EN
    // Init-sequence progress; every reset restarts the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_active_q <= 1'b1;
            init_idx_q    <= 3'd0;
            init_done_q   <= 1'b0;
        end else begin
            init_active_q <= init_active_d;
            init_idx_q    <= init_idx_d;
            init_done_q   <= init_done_d;
        end
    end

    assign o_init_done = init_done_q;
`else
    assign o_init_done = 1'b1;
`endif

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_req_drop     = drop_q;
    assign o_max7219_clk  = sclk_q;
    assign o_max7219_din  = din_q;
    assign o_max7219_load = load_q;

endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Self-checking bench for max7219_chain_ctrl (2 devices, divider 2). A
// behavioural model of the MAX7219 chain decodes the serial bus into per-device
// register files; expectations come from the words the bench itself sends.
module tb_max7219_chain_ctrl;

    localparam int N         = 2;
    localparam int D         = 2;
    localparam int FRAME_CYC = (32*N + 2) * D;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [3:0]   addr  = 4'h0;
    logic [8*N-1:0] data = '0;
    logic busy, done, drop, init_done, sclk, din, load;

    int total = 0;
    int bad   = 0;

    logic [7:0]     chip_reg [N][16];
    logic [7:0]     exp_reg  [N][16];
    logic [16*N-1:0] sr = '0;
    int rise_cnt = 0, load_cnt = 0, cyc = 0;
    int last_rise = -1000, last_din_chg = -1000;
    logic p_sclk = 1'b0, p_din = 1'b0, p_load = 1'b0, p_rst = 1'b0;

    always #5 clk = ~clk;

    max7219_chain_ctrl #(.G_NB_MATRIX(N), .G_CLK_DIV(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wr_en        (wr_en),
        .i_addr         (addr),
        .i_data         (data),
        .o_busy         (busy),
        .o_done         (done),
        .o_req_drop     (drop),
        .o_init_done    (init_done),
        .o_max7219_clk  (sclk),
        .o_max7219_din  (din),
        .o_max7219_load (load)
    );

    // Chain model and bus timing monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n || !p_rst) begin
            rise_cnt     = 0;
            last_rise    = -1000;
            last_din_chg = -1000;
        end else begin
            if (din !== p_din) begin
                last_din_chg = cyc;
                total++;
                if (cyc - last_rise < D) begin
                    bad++;
                    $display("FAIL din_hold: din changed %0d cycles after clk rise, need >= %0d", cyc - last_rise, D);
                end
            end
            if (sclk === 1'b1 && p_sclk === 1'b0) begin
                total++;
                if (cyc - last_din_chg < D || load !== 1'b0) begin
                    bad++;
                    $display("FAIL din_setup: setup=%0d load=%b, need setup>=%0d load=0", cyc - last_din_chg, load, D);
                end
                sr = {sr[16*N-2:0], din};
                rise_cnt++;
                last_rise = cyc;
            end
            if (load === 1'b1 && p_load === 1'b0) begin
                total++;
                if (rise_cnt != 16*N || sclk !== 1'b0) begin
                    bad++;
                    $display("FAIL edges_per_load: got %0d edges clk=%b, need %0d clk=0", rise_cnt, sclk, 16*N);
                end
                for (int i = 0; i < N; i++) begin
                    chip_reg[i][sr[16*i+8 +: 4]] = sr[16*i +: 8];
                end
                load_cnt++;
                rise_cnt = 0;
            end
        end
        p_sclk = sclk;
        p_din  = din;
        p_load = load;
        p_rst  = rst_n;
    end

    // Watchdog so that a stuck run still ends with a reported failure.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] a, input logic [8*N-1:0] d);
        wr_en = 1'b1;
        addr  = a;
        data  = d;
        for (int i = 0; i < N; i++) exp_reg[i][a] = d[8*i +: 8];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 5000) begin
            k++;
            @(negedge clk);
        end
    endtask

    task automatic check_regs(input logic [3:0] a, input string name);
        for (int i = 0; i < N; i++) begin
            total++;
            if (chip_reg[i][a] !== exp_reg[i][a]) begin
                bad++;
                $display("FAIL %s: dev%0d reg%0h got %02h need %02h", name, i, a, chip_reg[i][a], exp_reg[i][a]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, drop, sclk, din, load} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b need 000000", {busy, done, drop, sclk, din, load});
        end
        total++;
`ifdef MAX7219_CHAIN_INIT_SEQ_EN
        if (init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_init_done: got %b need 0", init_done);
        end
`else
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL reset_init_done: got %b need 1", init_done);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init();
`ifdef MAX7219_CHAIN_INIT_SEQ_EN
        int n, k;
        logic side_bad;
        k = 0;
        while (busy !== 1'b1 && k < 10) begin
            k++;
            @(negedge clk);
        end
        n = 0;
        side_bad = 1'b0;
        while (busy === 1'b1 && n < 5000) begin
            if (init_done !== 1'b0 || done !== 1'b0) side_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 5*FRAME_CYC) begin
            bad++;
            $display("FAIL init_busy_len: got %0d need %0d", n, 5*FRAME_CYC);
        end
        total++;
        if (side_bad || init_done !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL init_flags: during=%b init_done=%b done=%b need 0/1/0", side_bad, init_done, done);
        end
        for (int i = 0; i < N; i++) begin
            exp_reg[i][4'hC] = 8'h01;
            exp_reg[i][4'hB] = 8'h07;
            exp_reg[i][4'h9] = 8'h00;
            exp_reg[i][4'hA] = 8'h07;
            exp_reg[i][4'hF] = 8'h00;
        end
        check_regs(4'hC, "init_shutdown");
        check_regs(4'hB, "init_scan_limit");
        check_regs(4'h9, "init_decode");
        check_regs(4'hA, "init_intensity");
        check_regs(4'hF, "init_test");
`else
        logic seen_busy;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0) seen_busy = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen_busy || init_done !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: busy_seen=%b init_done=%b need 0/1", seen_busy, init_done);
        end
`endif
    endtask

    task automatic test_single();
        int n;
        wait_idle();
        send(4'h1, 16'hA55A);
        measure_busy(n);
        total++;
        if (n != FRAME_CYC || done !== 1'b1) begin
            bad++;
            $display("FAIL single_busy: busy=%0d done=%b need %0d/1", n, done, FRAME_CYC);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_width: got %b need 0", done);
        end
        total++;
        if (chip_reg[1][1] !== 8'hA5 || chip_reg[0][1] !== 8'h5A) begin
            bad++;
            $display("FAIL single_digit0: dev1=%02h dev0=%02h need a5/5a", chip_reg[1][1], chip_reg[0][1]);
        end
    endtask

    task automatic test_random();
        int n;
        logic [3:0] a;
        logic [8*N-1:0] d;
        for (int it = 0; it < 8; it++) begin
            a = 4'($urandom_range(1, 15));
            d = (8*N)'($urandom);
            wait_idle();
            send(a, d);
            measure_busy(n);
            total++;
            if (n != FRAME_CYC || done !== 1'b1) begin
                bad++;
                $display("FAIL random_busy: it=%0d busy=%0d done=%b need %0d/1", it, n, done, FRAME_CYC);
            end
            check_regs(a, "random_regs");
        end
    endtask

    task automatic test_drop();
        int n, loads0;
        logic extra;
        logic [8*N-1:0] d1;
        d1 = (8*N)'($urandom);
        wait_idle();
        @(negedge clk);
        send(4'h3, d1);
        loads0 = load_cnt;
        n = 1;
        @(negedge clk);
        while (busy === 1'b1 && n < 5000) begin
            if (n == 10) begin
                wr_en = 1'b1;
                addr  = 4'h3;
                data  = ~d1;
            end else begin
                wr_en = 1'b0;
            end
            if (n == 11) begin
                total++;
                if (drop !== 1'b1) begin
                    bad++;
                    $display("FAIL drop_pulse: got %b need 1", drop);
                end
            end
            if (n == 12) begin
                total++;
                if (drop !== 1'b0) begin
                    bad++;
                    $display("FAIL drop_width: got %b need 0", drop);
                end
            end
            n++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        total++;
        if (n != FRAME_CYC) begin
            bad++;
            $display("FAIL drop_busy_len: got %0d need %0d", n, FRAME_CYC);
        end
        check_regs(4'h3, "drop_regs");
        extra = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy !== 1'b0) extra = 1'b1;
            @(negedge clk);
        end
        total++;
        if (extra || load_cnt != loads0 + 1) begin
            bad++;
            $display("FAIL drop_no_second: busy_seen=%b loads=%0d need 0/%0d", extra, load_cnt - loads0, 1);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, loads0;
        wait_idle();
        loads0 = load_cnt;
        send(4'h6, 16'h1234);
        measure_busy(n1);
        total++;
        if (n1 != FRAME_CYC || done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: busy=%0d done=%b need %0d/1", n1, done, FRAME_CYC);
        end
        send(4'h7, 16'hBEEF);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap: busy=%b one cycle after done, need 1", busy);
        end
        measure_busy(n2);
        total++;
        if (n2 != FRAME_CYC || done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: busy=%0d done=%b need %0d/1", n2, done, FRAME_CYC);
        end
        total++;
        if (load_cnt != loads0 + 2) begin
            bad++;
            $display("FAIL b2b_loads: got %0d need 2", load_cnt - loads0);
        end
        check_regs(4'h6, "b2b_regs_a");
        check_regs(4'h7, "b2b_regs_b");
    endtask

    task automatic test_reset_mid();
        int n, loads0;
        wait_idle();
        send(4'h5, 16'h0FF0);
        measure_busy(n);
        check_regs(4'h5, "rstmid_setup");
        loads0 = load_cnt;
        wr_en = 1'b1;
        addr  = 4'h5;
        data  = 16'hC33C;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (49) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, drop, sclk, din, load} !== 6'b0) begin
            bad++;
            $display("FAIL rstmid_outputs: got %b need 000000", {busy, done, drop, sclk, din, load});
        end
        repeat (3) @(negedge clk);
        total++;
        if (load_cnt != loads0) begin
            bad++;
            $display("FAIL rstmid_no_load: got %0d loads need 0", load_cnt - loads0);
        end
        check_regs(4'h5, "rstmid_regs");
        rst_n = 1'b1;
        @(negedge clk);
        test_init();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            for (int r = 0; r < 16; r++) begin
                chip_reg[i][r] = 8'h00;
                exp_reg[i][r]  = 8'h00;
            end
        end
        @(negedge clk);
        test_reset();
        test_init();
        test_single();
        test_random();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
